// File: rtl/seg7_scan_pkg.sv
// Shared register map, CTRL layout and reset constant for the seg7_scan display controller.
package seg7_pkg;

  localparam int unsigned SEG7_VALUE = 0;
  localparam int unsigned SEG7_DP    = 1;
  localparam int unsigned SEG7_CTRL  = 2;
  localparam int unsigned SEG7_RAW0  = 3;

  localparam logic [31:0] SEG7_CTRL_RST = 32'h0000_00F1;

  localparam int unsigned CTRL_ON_BIT     = 0;
  localparam int unsigned CTRL_RAW_BIT    = 1;
  localparam int unsigned CTRL_BRIGHT_LSB = 4;
  localparam int unsigned CTRL_BLANK_LSB  = 8;

  typedef struct packed {
    logic [7:0] blank;
    logic [3:0] bright;
    logic       raw;
    logic       on;
  } ctrl_t;

  // Read-back image of CTRL; bits outside the defined fields read 0.
  function automatic logic [31:0] ctrl_pack(ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_ON_BIT]             = c.on;
    w[CTRL_RAW_BIT]            = c.raw;
    w[CTRL_BRIGHT_LSB +: 4]    = c.bright;
    w[CTRL_BLANK_LSB +: 8]     = c.blank;
    return w;
  endfunction

endpackage

// File: rtl/seg7_scan_hexdec.sv
// Combinational hex nibble to seven-segment glyph, active-high {g,f,e,d,c,b,a}; b and d are lowercase.
module seg7_hexdec (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    unique case (hex_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      4'hF: seg_o = 7'h71;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Memory-mapped multiplexed seven-segment controller: register bank, scan counters, registered outputs.
// Optional raw-segment registers are built when SEG7_SCAN_RAW_EN is defined.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h100,
  parameter int          DIGITS     = 4,
  parameter logic [15:0] SCAN_DIV   = 16'd1024,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              rw,
  input  logic [31:0]       addr,
  inout  wire  [31:0]       data,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  logic [31:0] off;
  logic        hit_value, hit_dp, hit_ctrl, hit_raw, hit_any;
  logic        wr_en, rd_en;
  logic [31:0] rd_data;

  logic [31:0] value_q;
  logic [7:0]  dp_q;
  ctrl_t       ctrl_q;

  logic [15:0] pcnt_q, pcnt_d;
  logic [3:0]  phase_q, phase_d;
  logic [2:0]  idx_q, idx_d;

  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        nibble;
  logic [6:0]        glyph;
  logic [7:0]        seg_act;
  logic              lit;

  assign off       = addr - BASE;
  assign hit_value = (off == 32'(SEG7_VALUE));
  assign hit_dp    = (off == 32'(SEG7_DP));
  assign hit_ctrl  = (off == 32'(SEG7_CTRL));
  assign hit_any   = hit_value | hit_dp | hit_ctrl | hit_raw;
  assign wr_en     = enable & rw;
  assign rd_en     = enable & ~rw & hit_any;

`ifdef SEG7_SCAN_RAW_EN
  logic [7:0] raw_q [8];
  logic [2:0] raw_sel;

  assign hit_raw = (off >= 32'(SEG7_RAW0)) && (off < 32'(SEG7_RAW0 + DIGITS));
  assign raw_sel = off[2:0] - 3'(SEG7_RAW0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) raw_q[i] <= '0;
    end else if (wr_en && hit_raw) begin
      raw_q[raw_sel] <= data[7:0];
    end
  end
`else
  assign hit_raw = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value_q       <= '0;
      dp_q          <= '0;
      ctrl_q.on     <= SEG7_CTRL_RST[CTRL_ON_BIT];
      ctrl_q.raw    <= SEG7_CTRL_RST[CTRL_RAW_BIT];
      ctrl_q.bright <= SEG7_CTRL_RST[CTRL_BRIGHT_LSB +: 4];
      ctrl_q.blank  <= SEG7_CTRL_RST[CTRL_BLANK_LSB +: 8];
    end else if (wr_en) begin
      if (hit_value) value_q <= data;
      if (hit_dp)    dp_q    <= data[7:0];
      if (hit_ctrl) begin
        ctrl_q.on     <= data[CTRL_ON_BIT];
`ifdef SEG7_SCAN_RAW_EN
        ctrl_q.raw    <= data[CTRL_RAW_BIT];
`else
        ctrl_q.raw    <= 1'b0;
`endif
        ctrl_q.bright <= data[CTRL_BRIGHT_LSB +: 4];
        ctrl_q.blank  <= data[CTRL_BLANK_LSB +: 8];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (hit_value)     rd_data = value_q;
    else if (hit_dp)   rd_data = {24'h0, dp_q};
    else if (hit_ctrl) rd_data = ctrl_pack(ctrl_q);
`ifdef SEG7_SCAN_RAW_EN
    else if (hit_raw)  rd_data = {24'h0, raw_q[raw_sel]};
`endif
  end

  assign data = rd_en ? rd_data : 'z;

  // Scanning free-runs regardless of CTRL.on so re-enabling keeps phase.
  always_comb begin
    pcnt_d  = pcnt_q + 16'd1;
    phase_d = phase_q;
    idx_d   = idx_q;
    if (pcnt_q == SCAN_DIV - 16'd1) begin
      pcnt_d  = '0;
      phase_d = phase_q + 4'd1;
      if (phase_q == 4'hF) begin
        idx_d = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt_q  <= '0;
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      pcnt_q  <= pcnt_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  assign nibble = value_q[{idx_q, 2'b00} +: 4];

  seg7_hexdec u_hexdec (
    .hex_i (nibble),
    .seg_o (glyph)
  );

  always_comb begin
    seg_act = {dp_q[idx_q], glyph};
`ifdef SEG7_SCAN_RAW_EN
    if (ctrl_q.raw) seg_act = raw_q[idx_q];
`endif
  end

  assign lit = ctrl_q.on & ~ctrl_q.blank[idx_q] & (phase_q <= ctrl_q.bright);

  always_comb begin
    seg_d = lit ? seg_act : 8'h00;
    an_d  = lit ? (DIGITS'(1) << idx_q) : '0;
    if (ACTIVE_LOW) begin
      seg_d = ~seg_d;
      an_d  = ~an_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_q <= {8{ACTIVE_LOW}};
      an_q  <= {DIGITS{ACTIVE_LOW}};
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (DIGITS=4, SCAN_DIV=2, active-low) against a cycle-count reference model.
module tb_seg7_scan;

  localparam int          D    = 4;
  localparam int          SD   = 2;
  localparam logic [31:0] BASE = 32'h100;
`ifdef SEG7_SCAN_RAW_EN
  localparam bit RAW_EN = 1'b1;
`else
  localparam bit RAW_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, enable, rw, drv;
  logic [31:0]   addr, wdat;
  tri1  [31:0]   data;
  logic [7:0]    seg;
  logic [D-1:0]  an;

  assign data = drv ? wdat : 'z;
  always #5 clk = ~clk;

  seg7_scan #(
    .BASE       (BASE),
    .DIGITS     (D),
    .SCAN_DIV   (16'(SD)),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .rw      (rw),
    .addr    (addr),
    .data    (data),
    .seg     (seg),
    .an      (an)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_value, m_ctrl;
  logic [7:0]  m_dp;
  logic [7:0]  m_raw [8];
  int          cyc;
  logic [7:0]  exp_seg;
  logic [D-1:0] exp_an;
  logic [6:0]  font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Expected outputs after this edge come from the state before it; then apply the edge.
  task automatic model_edge();
    int phase, idx, o;
    bit l;
    logic [7:0] s;
    logic [3:0] nib;
    if (!reset_n) begin
      exp_seg = 8'hFF; exp_an = '1; cyc = 0;
      m_value = '0; m_dp = '0; m_ctrl = 32'h0000_00F1;
      for (int i = 0; i < 8; i++) m_raw[i] = '0;
      return;
    end
    phase = (cyc / SD) % 16;
    idx   = (cyc / (16 * SD)) % D;
    l     = m_ctrl[0] && !m_ctrl[8 + idx] && (phase <= int'(m_ctrl[7:4]));
    nib   = m_value[idx*4 +: 4];
    s     = m_ctrl[1] ? m_raw[idx] : {m_dp[idx], font[nib]};
    exp_seg = l ? ~s : 8'hFF;
    exp_an  = l ? ~(D'(1) << idx) : '1;
    if (enable && rw) begin
      o = int'(addr - BASE);
      if (o == 0)      m_value = wdat;
      else if (o == 1) m_dp = wdat[7:0];
      else if (o == 2) m_ctrl = wdat & (RAW_EN ? 32'h0000_FFF3 : 32'h0000_FFF1);
      else if (RAW_EN && o >= 3 && o < 3 + D) m_raw[o-3] = wdat[7:0];
    end
    cyc++;
  endtask

  function automatic logic [31:0] model_read(int o);
    if (o == 0) return m_value;
    if (o == 1) return {24'h0, m_dp};
    if (o == 2) return m_ctrl;
    if (RAW_EN && o >= 3 && o < 3 + D) return {24'h0, m_raw[o-3]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus_write(input int o, input logic [31:0] v);
    enable = 1'b1; rw = 1'b1; addr = BASE + 32'(o); wdat = v; drv = 1'b1;
    step();
    enable = 1'b0; rw = 1'b0; drv = 1'b0;
  endtask

  task automatic bus_read(input int o, output logic [31:0] v);
    enable = 1'b1; rw = 1'b0; addr = BASE + 32'(o);
    #1;
    v = data;
    enable = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] steps [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    reset_n = 1'b0; enable = 1'b0; rw = 1'b0; drv = 1'b0; addr = '0; wdat = '0;
    step(); step();
    checks++;
    if (an !== 4'hF || seg !== 8'hFF) begin
      errors++; $display("FAIL reset_outputs an=%h seg=%h want an=F seg=FF", an, seg);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4 * 32 + 4; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++; $display("FAIL reset_scan i=%0d an=%h/%h seg=%h/%h", i, an, exp_an, seg, exp_seg);
      end
      if (i % 32 == 0) begin
        checks++;
        if (an !== steps[(i / 32) % 4]) begin
          errors++; $display("FAIL reset_step i=%0d an=%h want %h", i, an, steps[(i / 32) % 4]);
        end
      end
    end
  endtask

  task automatic test_value_dp();
    logic [31:0] rd;
    int n0 = 0, n1 = 0;
    bus_write(0, 32'h0000_1234);
    bus_write(1, 32'h0000_0002);
    for (int i = 0; i < 128; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++; $display("FAIL value_scan i=%0d an=%h/%h seg=%h/%h", i, an, exp_an, seg, exp_seg);
      end
      if (an === 4'hE) begin
        n0++; checks++;
        if (seg !== 8'h99) begin errors++; $display("FAIL digit0_glyph seg=%h want 99", seg); end
      end
      if (an === 4'hD) begin
        n1++; checks++;
        if (seg !== 8'h30) begin errors++; $display("FAIL digit1_glyph seg=%h want 30", seg); end
      end
    end
    checks++;
    if (n0 != 32 || n1 != 32) begin
      errors++; $display("FAIL value_lit_count d0=%0d d1=%0d want 32/32", n0, n1);
    end
    bus_read(0, rd);
    checks++;
    if (rd !== 32'h0000_1234) begin errors++; $display("FAIL value_readback got=%h want 00001234", rd); end
  endtask

  task automatic test_bright0();
    int nlit = 0;
    bus_write(2, 32'h0000_0001);
    for (int i = 0; i < 128; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++; $display("FAIL bright0_scan i=%0d an=%h/%h seg=%h/%h", i, an, exp_an, seg, exp_seg);
      end
      if (an !== 4'hF) nlit++;
    end
    checks++;
    if (nlit != 8) begin errors++; $display("FAIL bright0_duty lit=%0d want 8", nlit); end
  endtask

  task automatic test_blank();
    int bad = 0, n1 = 0, n3 = 0;
    bus_write(2, 32'h0000_05F1);
    for (int i = 0; i < 128; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++; $display("FAIL blank_scan i=%0d an=%h/%h seg=%h/%h", i, an, exp_an, seg, exp_seg);
      end
      if (an[0] !== 1'b1 || an[2] !== 1'b1) bad++;
      if (an === 4'hD) n1++;
      if (an === 4'h7) n3++;
    end
    checks++;
    if (bad != 0 || n1 != 32 || n3 != 32) begin
      errors++; $display("FAIL blank_mask bad=%0d d1=%0d d3=%0d want 0/32/32", bad, n1, n3);
    end
  endtask

  task automatic test_raw();
    logic [31:0] rd;
    int n2 = 0;
`ifdef SEG7_SCAN_RAW_EN
    bus_write(2, 32'h0000_00F1);
    bus_write(5, 32'h0000_0055);
    bus_write(2, 32'h0000_00F3);
    for (int i = 0; i < 128; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++; $display("FAIL raw_scan i=%0d an=%h/%h seg=%h/%h", i, an, exp_an, seg, exp_seg);
      end
      if (an === 4'hB) begin
        n2++; checks++;
        if (seg !== 8'hAA) begin errors++; $display("FAIL raw_digit2 seg=%h want AA", seg); end
      end
    end
    checks++;
    if (n2 != 32) begin errors++; $display("FAIL raw_lit_count d2=%0d want 32", n2); end
    bus_read(5, rd);
    checks++;
    if (rd !== 32'h0000_0055) begin errors++; $display("FAIL raw_readback got=%h want 00000055", rd); end
`else
    bus_read(5, rd);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL raw_undecoded got=%h want pulled-up FFFFFFFF", rd); end
    bus_write(2, 32'h0000_00F3);
    bus_read(2, rd);
    checks++;
    if (rd !== 32'h0000_00F1) begin errors++; $display("FAIL raw_ctrl_ignored got=%h want 000000F1", rd); end
    for (int i = 0; i < 64; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++; $display("FAIL hex_scan i=%0d an=%h/%h seg=%h/%h", i, an, exp_an, seg, exp_seg);
      end
      if (an === 4'hB) n2++;
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] rd, v;
    int o, len;
    for (int it = 0; it < 8; it++) begin
      bus_write(0, $urandom);
      bus_write(1, $urandom);
      v = $urandom;
      v[0] = ($urandom_range(0, 3) != 0);
      bus_write(2, v);
      if (RAW_EN) bus_write(3 + $urandom_range(0, D - 1), $urandom);
      len = $urandom_range(40, 120);
      for (int i = 0; i < len; i++) begin
        if (i == len / 2) begin
          bus_write($urandom_range(0, 1), $urandom);
        end else begin
          step();
        end
        checks++;
        if (an !== exp_an || seg !== exp_seg) begin
          errors++; $display("FAIL random_scan it=%0d i=%0d an=%h/%h seg=%h/%h", it, i, an, exp_an, seg, exp_seg);
        end
      end
      o = $urandom_range(0, 2 + (RAW_EN ? D : 0));
      bus_read(o, rd);
      checks++;
      if (rd !== model_read(o)) begin
        errors++; $display("FAIL random_readback off=%0d got=%h want %h", o, rd, model_read(o));
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (!(((cyc / 32) % D == 3) && (cyc % 32 == 10)) && guard < 300) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 300) begin errors++; $display("FAIL reset_mid_reach guard=%0d", guard); end
    checks++;
    if (an !== exp_an) begin errors++; $display("FAIL reset_mid_pre an=%h want %h", an, exp_an); end
    reset_n = 1'b0;
    step();
    checks++;
    if (an !== 4'hF || seg !== 8'hFF) begin
      errors++; $display("FAIL reset_mid_abort an=%h seg=%h want F/FF", an, seg);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (an !== 4'hE || seg !== 8'hC0) begin
      errors++; $display("FAIL reset_mid_restart an=%h seg=%h want E/C0", an, seg);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        errors++; $display("FAIL reset_mid_scan i=%0d an=%h/%h seg=%h/%h", i, an, exp_an, seg, exp_seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_value_dp();
    test_bright0();
    test_blank();
    test_raw();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
